// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier (and future divider).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } mult_state_t;

  // Widest operand abs_mag handles; callers extend into this width and truncate back.
  localparam int unsigned MAG_W = 32;

  // Magnitude of a value that is already sign- or zero-extended to MAG_W bits.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [MAG_W-1:0] value,
                                               input logic             is_signed);
    return (is_signed && value[MAG_W-1]) ? (~value + MAG_W'(1)) : value;
  endfunction

endpackage

// File: rtl/mult_pp_digit.sv
// Partial product of one K-bit multiplier digit and a wide multiplicand.
module mult_pp_digit #(
  parameter int unsigned K = 1,
  parameter int unsigned W = 16
) (
  input  logic [K-1:0] digit,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] pp
);

  always_comb begin
    pp = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (digit[i]) pp = pp + (mcand << i);
    end
  end

endmodule

// File: rtl/shift_add_mult.sv
// Iterative shift-and-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock,
// with per-transaction signed/unsigned select and early exit on a zero remaining multiplier.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned NBITS          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NBITS-1:0]   A,
  input  logic [NBITS-1:0]   B,
  input  logic               iSigned,
  input  logic               iValid,
  output logic               iReady,
  output logic [2*NBITS-1:0] result,
  output logic               oValid,
  input  logic               oReady
);

  localparam int unsigned K  = BITS_PER_CYCLE;
  localparam int unsigned RW = 2 * NBITS;

  if (NBITS % BITS_PER_CYCLE != 0) begin : g_bad_k
    $error("shift_add_mult: NBITS must be a multiple of BITS_PER_CYCLE");
  end
  if (NBITS > MAG_W) begin : g_bad_n
    $error("shift_add_mult: NBITS exceeds abs_mag width");
  end

  mult_state_t      state;
  mult_state_t      next_state;
  logic [NBITS-1:0] mag_a;
  logic [RW-1:0]    mag_b;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    pp;
  logic             neg;

  logic load;
  logic step;
  logic finish;
  logic done;
  logic bad_state;

  logic [MAG_W-1:0] ext_a;
  logic [MAG_W-1:0] ext_b;

  assign ext_a = iSigned ? MAG_W'($signed(A)) : MAG_W'(A);
  assign ext_b = iSigned ? MAG_W'($signed(B)) : MAG_W'(B);

  mult_pp_digit #(
    .K (K),
    .W (RW)
  ) u_pp (
    .digit (mag_a[K-1:0]),
    .mcand (mag_b),
    .pp    (pp)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iValid)       next_state = CALC;
      CALC:    if (mag_a == '0)  next_state = SEND;
      SEND:    if (oReady)       next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // Control strobes for the datapath; iReady is combinational so it drops with reset.
  always_comb begin
    iReady    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    done      = 1'b0;
    bad_state = 1'b0;
    case (state)
      IDLE: begin
        iReady = ~reset;
        load   = iValid & ~reset;
      end
      CALC: begin
        finish = (mag_a == '0);
        step   = (mag_a != '0);
      end
      SEND:    done      = oReady;
      default: bad_state = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      result <= '0;
      oValid <= 1'b0;
    end else begin
      if (load) begin
        mag_a <= NBITS'(abs_mag(ext_a, iSigned));
        mag_b <= RW'(NBITS'(abs_mag(ext_b, iSigned)));
        neg   <= iSigned & (A[NBITS-1] ^ B[NBITS-1]);
        acc   <= '0;
      end
      if (step) begin
        acc   <= acc + pp;
        mag_a <= mag_a >> K;
        mag_b <= mag_b << K;
      end
      if (finish) begin
        result <= neg ? (~acc + RW'(1)) : acc;
        oValid <= 1'b1;
      end
      if (done || bad_state) oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult at BITS_PER_CYCLE = 1, 2 and 4 (NBITS = 8).
module tb_shift_add_mult;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  a_s      [3];
  logic [7:0]  b_s      [3];
  logic        sgn_s    [3];
  logic        ivalid_s [3];
  logic        iready_s [3];
  logic [15:0] result_s [3];
  logic        ovalid_s [3];
  logic        oready_s [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    shift_add_mult #(
      .NBITS          (8),
      .BITS_PER_CYCLE (1 << g)
    ) u_dut (
      .clock   (clock),
      .reset   (reset),
      .A       (a_s[g]),
      .B       (b_s[g]),
      .iSigned (sgn_s[g]),
      .iValid  (ivalid_s[g]),
      .iReady  (iready_s[g]),
      .result  (result_s[g]),
      .oValid  (ovalid_s[g]),
      .oReady  (oready_s[g])
    );
  end

  typedef struct {
    int          idx;
    logic [15:0] v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops the scoreboard and compares.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && ovalid_s[i] && oready_s[i]) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output[k%0d]: got %0h expected none", 1 << i, result_s[i]);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("result[k%0d]", 1 << i), 32'(result_s[i]), 32'(mon_e.v));
          check($sformatf("unit[k%0d]", 1 << i), 32'(i), 32'(mon_e.idx));
        end
      end
    end
  end

  // One transaction: issue, measure latency, stall oReady for hold cycles, then retire.
  task automatic run(input int idx, input logic [7:0] av, input logic [7:0] bv,
                     input logic s, input logic [15:0] ev, input int exp_lat,
                     input int hold, input string name);
    int   lat;
    int   w;
    exp_t e;
    w = 0;
    while (!iready_s[idx] && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    check({name, " iready_before"}, 32'(iready_s[idx]), 32'd1);
    a_s[idx]      = av;
    b_s[idx]      = bv;
    sgn_s[idx]    = s;
    ivalid_s[idx] = 1'b1;
    e.idx = idx;
    e.v   = ev;
    sb_q.push_back(e);
    @(posedge clock); #1;
    ivalid_s[idx] = 1'b0;
    a_s[idx]      = 8'hA5;
    b_s[idx]      = 8'h5A;
    sgn_s[idx]    = ~s;
    lat = 0;
    while (!ovalid_s[idx] && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({name, " ovalid_rise"}, 32'(ovalid_s[idx]), 32'd1);
    if (!ovalid_s[idx]) void'(sb_q.pop_back());
    if (exp_lat >= 0) check({name, " latency"}, 32'(lat), 32'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      check({name, " held_result"}, 32'(result_s[idx]), 32'(ev));
      check({name, " held_ovalid"}, 32'(ovalid_s[idx]), 32'd1);
      check({name, " held_iready"}, 32'(iready_s[idx]), 32'd0);
      @(posedge clock); #1;
    end
    oready_s[idx] = 1'b1;
    @(posedge clock); #1;
    oready_s[idx] = 1'b0;
    check({name, " ovalid_drop"}, 32'(ovalid_s[idx]), 32'd0);
    check({name, " iready_after"}, 32'(iready_s[idx]), 32'd1);
    check({name, " result_kept"}, 32'(result_s[idx]), 32'(ev));
  endtask

  task automatic run_rand(input int idx);
    logic [7:0]         av;
    logic [7:0]         bv;
    logic               s;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic [15:0]        ev;
    av = 8'($urandom);
    bv = 8'($urandom);
    s  = 1'($urandom_range(0, 1));
    sa = 16'($signed(av));
    sb = 16'($signed(bv));
    ev = s ? 16'(sa * sb) : 16'(16'(av) * 16'(bv));
    run(idx, av, bv, s, ev, -1, int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = '0; b_s[i] = '0; sgn_s[i] = 1'b0;
      ivalid_s[i] = 1'b0; oready_s[i] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_result", 32'(result_s[i]), 32'd0);
      check("reset_ovalid", 32'(ovalid_s[i]), 32'd0);
      check("reset_iready", 32'(iready_s[i]), 32'd0);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("release_iready", 32'(iready_s[i]), 32'd1);

    // K=1
    run(0, 8'd12,  8'd11,  1'b0, 16'd132,   5, 0, "k1_12x11");
    run(0, 8'hFD,  8'd5,   1'b1, 16'hFFF1,  3, 0, "k1_m3x5");
    run(0, 8'h80,  8'h80,  1'b1, 16'h4000,  9, 0, "k1_m128xm128");
    run(0, 8'd255, 8'd255, 1'b0, 16'hFE01,  9, 0, "k1_255x255");
    run(0, 8'd0,   8'd99,  1'b0, 16'd0,     1, 0, "k1_0x99");
    run(0, 8'd12,  8'd11,  1'b0, 16'd132,   5, 3, "k1_stall");
    // K=2
    run(1, 8'd12,  8'd11,  1'b0, 16'd132,   3, 0, "k2_12x11");
    run(1, 8'd0,   8'd99,  1'b0, 16'd0,     1, 0, "k2_0x99");
    run(1, 8'h80,  8'd127, 1'b1, 16'hC080,  5, 1, "k2_m128x127");
    // K=4
    run(2, 8'd255, 8'd255, 1'b0, 16'hFE01,  3, 0, "k4_255x255");
    run(2, 8'hFF,  8'hFF,  1'b1, 16'd1,     2, 0, "k4_m1xm1");
    run(2, 8'd5,   8'hF9,  1'b1, 16'hFFDD,  2, 2, "k4_5xm7");

    // Reset pulse mid-CALC discards the transaction.
    a_s[0] = 8'd200; b_s[0] = 8'd200; sgn_s[0] = 1'b0; ivalid_s[0] = 1'b1;
    @(posedge clock); #1;
    ivalid_s[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midcalc_iready_in_reset", 32'(iready_s[0]), 32'd0);
    @(posedge clock); #1;
    check("midcalc_ovalid", 32'(ovalid_s[0]), 32'd0);
    reset = 1'b0;
    #1;
    check("midcalc_iready_release", 32'(iready_s[0]), 32'd1);
    seen = 0;
    oready_s[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (ovalid_s[0]) seen = 1;
    end
    oready_s[0] = 1'b0;
    check("midcalc_no_output", 32'(seen), 32'd0);
    run(0, 8'd7, 8'd6, 1'b0, 16'd42, 4, 0, "after_reset_7x6");

    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 6; r++) run_rand(i);
    end

    repeat (2) @(posedge clock);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
